// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: IF/ID/EX/MEM/WB sequencer driving the
// datapath control strobes, ALU operation select and a retired counter.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  memReady,
    output logic                  irWrite,
    output logic                  pcWrite,
    output logic                  branch,
    output logic                  jump,
    output logic                  memRead,
    output logic                  memWrite,
    output logic                  memToReg,
    output logic                  aluSrc,
    output logic                  regWrite,
    output logic [ALU_CTRL_W-1:0] aluCtrl,
    output logic                  illegal,
    output logic [2:0]            state_o,
    output logic [CNT_W-1:0]      retired
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             retire;
    logic [3:0]       alu_op;
    logic             legal;

    // funct3 decode shared by R and I-ALU; the caller decides whether
    // funct7b5 may select SUB and/or SRA.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                  input logic       use_sub,
                                                  input logic       use_sra);
        case (f3)
            3'b000:  alu_from_funct = use_sub ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_funct = ALU_SLL;
            3'b010:  alu_from_funct = ALU_SLT;
            3'b011:  alu_from_funct = ALU_SLTU;
            3'b100:  alu_from_funct = ALU_XOR;
            3'b101:  alu_from_funct = use_sra ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_funct = ALU_OR;
            default: alu_from_funct = ALU_AND;
        endcase
    endfunction

    // Opcode legality check used in ID
    always_comb begin
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
    end

    // State register and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IF;
            count <= '0;
        end else begin
            state <= state_next;
            if (retire) count <= count + 1'b1;
        end
    end

    // Next-state and control decode; reset forces the idle IF request
    always_comb begin
        state_next = S_IF;
        retire     = 1'b0;
        alu_op     = ALU_ADD;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memToReg   = 1'b0;
        aluSrc     = 1'b0;
        regWrite   = 1'b0;
        illegal    = 1'b0;
        aluCtrl    = '0;

        case (state)
            S_IF: begin
                memRead = 1'b1;
                if (memReady) begin
                    irWrite    = 1'b1;
                    pcWrite    = 1'b1;
                    state_next = S_ID;
                end else begin
                    state_next = S_IF;
                end
            end
            S_ID: begin
                if (legal) begin
                    state_next = S_EX;
                end else begin
                    illegal    = 1'b1;
                    state_next = S_IF;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_op     = alu_from_funct(funct3, funct7b5, funct7b5);
                        state_next = S_WB;
                    end
                    OP_I: begin
                        aluSrc     = 1'b1;
                        alu_op     = alu_from_funct(funct3, 1'b0, funct7b5);
                        state_next = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        aluSrc     = 1'b1;
                        state_next = S_MEM;
                    end
                    OP_LUI, OP_AUIPC: begin
                        aluSrc     = 1'b1;
                        state_next = S_WB;
                    end
                    OP_BRANCH: begin
                        branch = 1'b1;
                        case (funct3[2:1])
                            2'b00:   alu_op = ALU_SUB;
                            2'b10:   alu_op = ALU_SLT;
                            2'b11:   alu_op = ALU_SLTU;
                            default: alu_op = ALU_ADD;
                        endcase
                        retire     = 1'b1;
                        state_next = S_IF;
                    end
                    OP_JAL, OP_JALR: begin
                        jump       = 1'b1;
                        aluSrc     = 1'b1;
                        state_next = S_WB;
                    end
                    default: state_next = S_IF;
                endcase
                aluCtrl = ALU_CTRL_W'(alu_op);
            end
            S_MEM: begin
                if (opcode == OP_STORE) begin
                    memWrite = 1'b1;
                    if (memReady) begin
                        retire     = 1'b1;
                        state_next = S_IF;
                    end else begin
                        state_next = S_MEM;
                    end
                end else if (opcode == OP_LOAD) begin
                    memRead    = 1'b1;
                    state_next = memReady ? S_WB : S_MEM;
                end else begin
                    state_next = S_IF;
                end
            end
            S_WB: begin
                regWrite   = 1'b1;
                memToReg   = (opcode == OP_LOAD);
                retire     = 1'b1;
                state_next = S_IF;
            end
            default: state_next = S_IF;
        endcase

        if (!rst) begin
            irWrite  = 1'b0;
            pcWrite  = 1'b0;
            branch   = 1'b0;
            jump     = 1'b0;
            memRead  = 1'b1;
            memWrite = 1'b0;
            memToReg = 1'b0;
            aluSrc   = 1'b0;
            regWrite = 1'b0;
            illegal  = 1'b0;
            aluCtrl  = '0;
        end
    end

    // Visible state and count read as zero while reset is held
    always_comb begin
        state_o = rst ? state : 3'd0;
        retired = rst ? count : '0;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALU_CTRL_W, default 4: aluCtrl width; SHALL be >= 4, codes zero-extended.
REQ-002 Parameter CNT_W, default 32: retired-instruction counter width.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 opcode  in  7  instruction[6:0] from instruction register, stable ID..end of instruction.
REQ-006 funct3  in  3  instruction[14:12].
REQ-007 funct7b5  in  1  instruction[30].
REQ-008 memReady  in  1  memory handshake; access completes in the cycle it is 1 while request asserted.
REQ-009 irWrite, pcWrite  out  1 each  load IR / advance PC+4.
REQ-010 branch, jump  out  1 each  conditional branch / JAL-JALR PC redirect qualifiers.
REQ-011 memRead, memWrite, memToReg, aluSrc, regWrite  out  1 each  datapath controls.
REQ-012 aluCtrl  out  ALU_CTRL_W  ALU operation.
REQ-013 illegal  out  1  one-cycle pulse on undecodable opcode.
REQ-014 state_o  out  3  current state encoding.
REQ-015 retired  out  CNT_W  count of completed instructions.

Function
REQ-016 States SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4; encodings 5-7 SHALL go to IF next cycle with all controls 0.
REQ-017 Legal opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-018 Controls not explicitly asserted below SHALL be 0; aluCtrl SHALL be 0 outside EX.
REQ-019 IF: memRead=1; stay while memReady=0; when memReady=1, irWrite=1, pcWrite=1 that cycle, next ID.
REQ-020 ID: legal opcode -> EX; illegal -> IF with illegal=1 for that one ID cycle; retired unchanged.
REQ-021 EX, R: aluSrc=0, aluCtrl from funct3/funct7b5; next WB.
REQ-022 EX, I-ALU: aluSrc=1, aluCtrl from funct3; funct7b5 honoured only for funct3=101 (SRAI); next WB.
REQ-023 EX, LOAD/STORE/LUI/AUIPC: aluSrc=1, aluCtrl=ADD; LOAD/STORE -> MEM, LUI/AUIPC -> WB.
REQ-024 EX, BRANCH: branch=1; aluCtrl SUB for funct3 000/001, SLT for 100/101, SLTU for 110/111, ADD otherwise; next IF.
REQ-025 EX, JAL/JALR: jump=1, aluSrc=1, aluCtrl=ADD; next WB.
REQ-026 ALU codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
REQ-027 funct3 map: 000 ADD (SUB if R and funct7b5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7b5), 110 OR, 111 AND.
REQ-028 MEM: LOAD memRead=1, STORE memWrite=1, held while memReady=0; on memReady=1 LOAD -> WB, STORE -> IF.
REQ-029 WB: regWrite=1; memToReg=1 only for LOAD; next IF.
REQ-030 retired SHALL increment by 1 on the cycle of each transition WB->IF, MEM->IF (store), EX->IF (branch); wraps 2^CNT_W-1 -> 0.
REQ-031 memReady SHALL be ignored in ID, EX, WB.

Reset
REQ-032 rst=0 at a rising edge: state=IF, retired=0, regardless of current state, including mid-MEM wait.
REQ-033 While rst=0 all outputs SHALL be 0 except memRead=1 (IF) and state_o=0; memReady ignored.
REQ-034 First IF access begins the cycle after rst returns to 1.

Verification
REQ-035 R-type SUB (funct3=000, funct7b5=1), memReady=1 in IF -> states IF,ID,EX,WB,IF; aluCtrl=1 in EX; regWrite=1 in WB; retired 0->1.
REQ-036 LOAD, memReady low 3 cycles in MEM -> memRead held 4 MEM cycles, then WB memToReg=1, regWrite=1.
REQ-037 BRANCH funct3=110 -> EX aluCtrl=9, branch=1, then IF; retired +1; no WB.
REQ-038 Opcode 1111111 -> illegal=1 one cycle in ID, next IF, retired unchanged.
REQ-039 rst=0 asserted during MEM-wait store -> memWrite=0, state_o=0, retired=0 next cycle.
REQ-040 CNT_W=4, 16 completed instructions -> retired wraps 15->0.
